// File: rtl/quota_mapper.sv
// Converts a signed quantised value into the count of ones a unipolar stochastic
// stream of length BITSTREAM must carry. Provides a combinational result and a valid-tagged registered copy.
module quota_mapper #(
    parameter int BITSTREAM = 64,
    parameter int QUANT     = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [QUANT-1:0]             data,
    input  logic                         in_valid,
    output logic [$clog2(BITSTREAM)-1:0] quota,
    output logic [$clog2(BITSTREAM)-1:0] quota_r,
    output logic                         out_valid
);

    localparam int W  = $clog2(BITSTREAM);
    localparam int SW = QUANT + W + 1;
    localparam logic [SW-1:0] HALF = SW'(1) << (QUANT - 1);

    logic [QUANT-1:0] u_code;
    logic [SW-1:0]    scaled;
    logic [SW-1:0]    rounded;
    logic [SW-1:0]    s_full;

    // Adding H modulo 2^QUANT is the same as flipping the sign bit (offset binary).
    genvar gi;
    generate
        for (gi = 0; gi < QUANT; gi++) begin : g_offset
            if (gi == QUANT - 1) begin : g_msb
                assign u_code[gi] = ~data[gi];
            end else begin : g_low
                assign u_code[gi] = data[gi];
            end
        end
    endgenerate

    // BITSTREAM is a power of two, so the multiply is a shift; the wide sum cannot overflow.
    assign scaled  = SW'(u_code) << W;
    assign rounded = scaled + HALF;
    assign s_full  = rounded >> QUANT;

    // Keeping only W bits deliberately wraps s == BITSTREAM to zero.
    assign quota = s_full[W-1:0];

    logic [W-1:0] quota_reg;
    logic [W-1:0] quota_next;
    logic         valid_reg;
    logic         valid_next;

    always_comb begin
        quota_next = quota_reg;
        valid_next = in_valid;
        if (in_valid) begin
            quota_next = quota;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            quota_reg <= '0;
            valid_reg <= 1'b0;
        end else begin
            quota_reg <= quota_next;
            valid_reg <= valid_next;
        end
    end

    assign quota_r   = quota_reg;
    assign out_valid = valid_reg;

endmodule

// File: tb/tb_quota_mapper.sv
// Bench for quota_mapper (BITSTREAM=64, QUANT=8): directed table, full code sweep,
// random combinational values and a randomised registered-path run against an arithmetic model.
module tb_quota_mapper;

    localparam int BITSTREAM = 64;
    localparam int QUANT     = 8;
    localparam int W         = 6;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [7:0]   data;
    logic         in_valid;
    logic [W-1:0] quota;
    logic [W-1:0] quota_r;
    logic         out_valid;

    int n_cmp = 0;
    int n_bad = 0;

    quota_mapper #(.BITSTREAM(BITSTREAM), .QUANT(QUANT)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .data     (data),
        .in_valid (in_valid),
        .quota    (quota),
        .quota_r  (quota_r),
        .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    // Reference: interpret the code as signed, offset by H, scale, round, wrap.
    function automatic int ref_quota(input int code);
        int q;
        int u;
        int s;
        q = (code >= 128) ? code - 256 : code;
        u = ((q + 128) % 256 + 256) % 256;
        s = (u * BITSTREAM + 128) / 256;
        return s % BITSTREAM;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    typedef struct { logic [7:0] code; int exp; } dir_t;
    dir_t dir_tab[9];

    int exp_q;
    int exp_v;
    int code;

    initial begin
        dir_tab[0] = '{8'h00, 32};
        dir_tab[1] = '{8'h01, 32};
        dir_tab[2] = '{8'h02, 33};
        dir_tab[3] = '{8'hC0, 16};
        dir_tab[4] = '{8'h81, 0};
        dir_tab[5] = '{8'h80, 0};
        dir_tab[6] = '{8'h7D, 63};
        dir_tab[7] = '{8'h7E, 0};
        dir_tab[8] = '{8'h7F, 0};

        rst_n    = 1'b0;
        in_valid = 1'b1;
        data     = 8'h02;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("reset_quota_r", 32'(quota_r), 0);
        chk("reset_out_valid", 32'(out_valid), 0);
        chk("reset_comb_quota", 32'(quota), 33);

        for (int i = 0; i < 9; i++) begin
            data = dir_tab[i].code;
            #1;
            $display("directed data=%02h quota=%0d", data, quota);
            chk($sformatf("directed_%02h", dir_tab[i].code), 32'(quota), 32'(dir_tab[i].exp));
        end

        for (int q = -127; q <= 128; q++) begin
            data = 8'(q);
            #1;
            chk($sformatf("sweep_q%0d", q), 32'(quota), 32'(ref_quota(int'(data))));
        end

        for (int i = 0; i < 1000; i++) begin
            data = 8'($urandom_range(0, 254) - 127);
            #1;
            chk($sformatf("rand_%02h", data), 32'(quota), 32'(ref_quota(int'(data))));
        end

        // Directed registered path
        rst_n    = 1'b1;
        in_valid = 1'b1;
        data     = 8'h02;
        @(posedge clk); #1;
        $display("reg data=02 in_valid=1 quota_r=%0d out_valid=%0d", quota_r, out_valid);
        chk("reg_load_quota_r", 32'(quota_r), 33);
        chk("reg_load_out_valid", 32'(out_valid), 1);
        in_valid = 1'b0;
        data     = 8'hC0;
        @(posedge clk); #1;
        $display("reg data=c0 in_valid=0 quota_r=%0d out_valid=%0d", quota_r, out_valid);
        chk("reg_hold_quota_r", 32'(quota_r), 33);
        chk("reg_hold_out_valid", 32'(out_valid), 0);
        chk("reg_hold_comb", 32'(quota), 16);

        // Mid-stream reset with in_valid high drops the result
        in_valid = 1'b1;
        data     = 8'h7D;
        rst_n    = 1'b0;
        @(posedge clk); #1;
        $display("reg reset quota_r=%0d out_valid=%0d", quota_r, out_valid);
        chk("midreset_quota_r", 32'(quota_r), 0);
        chk("midreset_out_valid", 32'(out_valid), 0);
        chk("midreset_comb", 32'(quota), 63);
        rst_n = 1'b1;

        // Randomised registered run
        exp_q = 0;
        exp_v = 0;
        for (int i = 0; i < 300; i++) begin
            code     = int'($urandom_range(0, 255));
            data     = 8'(code);
            in_valid = 1'($urandom_range(0, 1));
            rst_n    = ($urandom_range(0, 19) == 0) ? 1'b0 : 1'b1;
            @(posedge clk); #1;
            if (!rst_n) begin
                exp_q = 0;
                exp_v = 0;
            end else begin
                exp_v = int'(in_valid);
                if (in_valid) exp_q = ref_quota(code);
            end
            chk($sformatf("rnd_reg_q_%0d", i), 32'(quota_r), 32'(exp_q));
            chk($sformatf("rnd_reg_v_%0d", i), 32'(out_valid), 32'(exp_v));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
